lisnoc_flit_sink: RTL and testbench



---
 rtl/lisnoc_pkg.sv | 22 ++
 rtl/lisnoc_ready_gen.sv | 20 ++
 rtl/lisnoc_flit_sink.sv | 121 ++++++++++++
 tb/tb_lisnoc_flit_sink.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lisnoc_pkg.sv
// Shared LISNoC definitions: flit type encoding, error codes and sink FSM states.
// The flit source stage uses the same type constants.
package lisnoc_pkg;

    localparam int FLIT_TYPE_WIDTH = 2;

    localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_TYPE_PAYLOAD = 2'b00;
    localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_TYPE_HEADER  = 2'b01;
    localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_TYPE_LAST    = 2'b10;
    localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_TYPE_SINGLE  = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_STRAY   = 2'd1;
    localparam logic [1:0] ERR_ABORT   = 2'd2;
    localparam logic [1:0] ERR_OVERLEN = 2'd3;

    typedef enum logic {
        SINK_IDLE  = 1'b0,
        SINK_INPKT = 1'b1
    } sink_state_t;

endpackage

// File: rtl/lisnoc_ready_gen.sv
// Rotating backpressure generator: a free-running 3-bit phase selects one
// bit of READY_MASK, independent of upstream valid.
module lisnoc_ready_gen #(
    parameter logic [7:0] READY_MASK = 8'hFF
) (
    input  logic clk,
    input  logic rst,
    output logic ready
);

    logic [2:0] phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= 3'd0;
        else     phase <= phase + 3'd1;
    end

    assign ready = READY_MASK[phase];

endmodule

// File: rtl/lisnoc_flit_sink.sv
// Flit sink endpoint: applies backpressure, checks packet framing, counts
// flits/packets and reports per-packet length, XOR checksum and first error.
module lisnoc_flit_sink
    import lisnoc_pkg::*;
#(
    parameter int         FLIT_DATA_WIDTH = 32,
    parameter logic [7:0] READY_MASK      = 8'hFF,
    parameter int         MAX_PKT_LEN     = 16,
    localparam int        FLIT_WIDTH      = FLIT_DATA_WIDTH + 2,
    localparam int        LEN_W           = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLIT_WIDTH-1:0]      flit_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    output logic [15:0]                flit_count,
    output logic [15:0]                pkt_count,
    output logic                       pkt_done,
    output logic [LEN_W-1:0]           pkt_len,
    output logic [FLIT_DATA_WIDTH-1:0] pkt_checksum,
    output logic                       error,
    output logic [1:0]                 error_code,
    output logic [FLIT_WIDTH-1:0]      error_flit
);

    sink_state_t                state;
    logic [LEN_W-1:0]           len;
    logic [FLIT_DATA_WIDTH-1:0] acc;

    logic                       xfer;
    logic [1:0]                 ftype;
    logic [FLIT_DATA_WIDTH-1:0] data;
    logic                       len_full;
    logic [LEN_W-1:0]           len_inc;
    logic [1:0]                 err_now;

    lisnoc_ready_gen #(.READY_MASK(READY_MASK)) u_ready_gen (
        .clk   (clk),
        .rst   (rst),
        .ready (ready_out)
    );

    assign xfer     = valid_in && ready_out;
    assign ftype    = flit_in[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
    assign data     = flit_in[FLIT_DATA_WIDTH-1:0];
    assign len_full = (len == LEN_W'(MAX_PKT_LEN));
    // length saturates; the overflowing flit is still accumulated
    assign len_inc  = len_full ? len : len + LEN_W'(1);

    always_comb begin
        err_now = ERR_NONE;
        if (state == SINK_IDLE) begin
            if (ftype == FLIT_TYPE_PAYLOAD || ftype == FLIT_TYPE_LAST)
                err_now = ERR_STRAY;
        end else begin
            if (ftype == FLIT_TYPE_HEADER || ftype == FLIT_TYPE_SINGLE)
                err_now = ERR_ABORT;
            else if (len_full)
                err_now = ERR_OVERLEN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SINK_IDLE;
            len          <= '0;
            acc          <= '0;
            flit_count   <= 16'd0;
            pkt_count    <= 16'd0;
            pkt_done     <= 1'b0;
            pkt_len      <= '0;
            pkt_checksum <= '0;
            error        <= 1'b0;
            error_code   <= ERR_NONE;
            error_flit   <= '0;
        end else begin
            pkt_done <= 1'b0;
            if (xfer) begin
                flit_count <= flit_count + 16'd1;
                if (err_now != ERR_NONE && !error) begin
                    error      <= 1'b1;
                    error_code <= err_now;
                    error_flit <= flit_in;
                end
                // HEADER always (re)starts a packet, SINGLE always completes one;
                // the abort of an open packet is only visible as an error
                case (ftype)
                    FLIT_TYPE_HEADER: begin
                        state <= SINK_INPKT;
                        len   <= LEN_W'(1);
                        acc   <= data;
                    end
                    FLIT_TYPE_SINGLE: begin
                        state        <= SINK_IDLE;
                        pkt_done     <= 1'b1;
                        pkt_len      <= LEN_W'(1);
                        pkt_checksum <= data;
                        pkt_count    <= pkt_count + 16'd1;
                    end
                    FLIT_TYPE_PAYLOAD: begin
                        if (state == SINK_INPKT) begin
                            len <= len_inc;
                            acc <= acc ^ data;
                        end
                    end
                    default: begin
                        if (state == SINK_INPKT) begin
                            state        <= SINK_IDLE;
                            pkt_done     <= 1'b1;
                            pkt_len      <= len_inc;
                            pkt_checksum <= acc ^ data;
                            pkt_count    <= pkt_count + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lisnoc_flit_sink.sv
// Bench for lisnoc_flit_sink: vector table, directed corner sequences and
// randomized traffic checked against a queue-based packet model.
module tb_lisnoc_flit_sink;
    import lisnoc_pkg::*;

    logic        clk, rst, sel, valid;
    logic [33:0] flit;
    logic        r0, r1, d0, d1, e0, e1;
    logic [15:0] fc0, fc1, pc0, pc1;
    logic [4:0]  len0;
    logic [2:0]  len1;
    logic [31:0] ck0, ck1;
    logic [1:0]  ec0, ec1;
    logic [33:0] ef0, ef1;

    // sel picks which instance receives traffic and is observed
    lisnoc_flit_sink #(.FLIT_DATA_WIDTH(32), .READY_MASK(8'hFF), .MAX_PKT_LEN(16)) dut0 (
        .clk(clk), .rst(rst), .flit_in(flit), .valid_in(valid & ~sel), .ready_out(r0),
        .flit_count(fc0), .pkt_count(pc0), .pkt_done(d0), .pkt_len(len0),
        .pkt_checksum(ck0), .error(e0), .error_code(ec0), .error_flit(ef0));

    lisnoc_flit_sink #(.FLIT_DATA_WIDTH(32), .READY_MASK(8'hAA), .MAX_PKT_LEN(4)) dut1 (
        .clk(clk), .rst(rst), .flit_in(flit), .valid_in(valid & sel), .ready_out(r1),
        .flit_count(fc1), .pkt_count(pc1), .pkt_done(d1), .pkt_len(len1),
        .pkt_checksum(ck1), .error(e1), .error_code(ec1), .error_flit(ef1));

    logic        o_rdy, o_done, o_err;
    logic [15:0] o_fc, o_pc;
    logic [4:0]  o_len;
    logic [31:0] o_ck;
    logic [1:0]  o_ec;
    logic [33:0] o_ef;
    assign o_rdy  = sel ? r1 : r0;
    assign o_done = sel ? d1 : d0;
    assign o_err  = sel ? e1 : e0;
    assign o_fc   = sel ? fc1 : fc0;
    assign o_pc   = sel ? pc1 : pc0;
    assign o_len  = sel ? {2'b00, len1} : len0;
    assign o_ck   = sel ? ck1 : ck0;
    assign o_ec   = sel ? ec1 : ec0;
    assign o_ef   = sel ? ef1 : ef0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // posedges since reset release; the mask bit for this count is the expected ready
    int unsigned cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_vec = 0, n_miss = 0;

    // reference model: packet contents as a queue of data words
    logic [31:0] m_q[$];
    bit          m_inpkt, m_done, m_err;
    logic [15:0] m_fc, m_pc;
    int          m_len;
    logic [31:0] m_ck;
    logic [1:0]  m_code;
    logic [33:0] m_ef;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int mmax();
        return sel ? 4 : 16;
    endfunction

    function automatic logic exp_ready();
        logic [7:0] m;
        m = sel ? 8'hAA : 8'hFF;
        return m[cyc % 8];
    endfunction

    task automatic model_reset();
        m_q.delete(); m_inpkt = 0; m_done = 0; m_err = 0;
        m_fc = 0; m_pc = 0; m_len = 0; m_ck = 0; m_code = 0; m_ef = 0;
    endtask

    function automatic void m_raise(input logic [1:0] c, input logic [33:0] f);
        if (!m_err) begin m_err = 1; m_code = c; m_ef = f; end
    endfunction

    function automatic void m_complete();
        logic [31:0] x = 0;
        foreach (m_q[i]) x ^= m_q[i];
        m_done = 1;
        m_len  = (m_q.size() > mmax()) ? mmax() : m_q.size();
        m_ck   = x;
        m_pc++;
        m_inpkt = 0;
    endfunction

    function automatic void model_accept(input logic [1:0] t, input logic [31:0] d);
        m_fc++;
        m_done = 0;
        case (t)
            FLIT_TYPE_HEADER: begin
                if (m_inpkt) m_raise(ERR_ABORT, {t, d});
                m_q = {d}; m_inpkt = 1;
            end
            FLIT_TYPE_SINGLE: begin
                if (m_inpkt) m_raise(ERR_ABORT, {t, d});
                m_q = {d}; m_complete();
            end
            default: begin
                if (!m_inpkt) m_raise(ERR_STRAY, {t, d});
                else begin
                    if (m_q.size() >= mmax()) m_raise(ERR_OVERLEN, {t, d});
                    m_q.push_back(d);
                    if (t == FLIT_TYPE_LAST) m_complete();
                end
            end
        endcase
    endfunction

    task automatic cmp_model();
        chk("flit_count", o_fc, m_fc);
        chk("pkt_count", o_pc, m_pc);
        chk("pkt_done", o_done, m_done);
        chk("pkt_len", o_len, m_len);
        chk("pkt_checksum", o_ck, m_ck);
        chk("error", o_err, m_err);
        chk("error_code", o_ec, m_code);
        chk("error_flit", o_ef, m_ef);
    endtask

    // called and returns at a negedge; holds valid until the handshake edge
    task automatic xfer(input logic [1:0] t, input logic [31:0] d);
        int guard = 0;
        flit = {t, d}; valid = 1;
        forever begin
            chk("ready_out", o_rdy, exp_ready());
            if (o_rdy) break;
            @(negedge clk);
            if (++guard > 32) begin
                chk("handshake timeout", 0, 1);
                valid = 0;
                return;
            end
        end
        @(posedge clk);
        model_accept(t, d);
        @(negedge clk);
        valid = 0;
        cmp_model();
        m_done = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("ready_out idle", o_rdy, exp_ready());
            cmp_model();
        end
    endtask

    task automatic do_reset(input logic s);
        @(negedge clk);
        rst = 1; valid = 0; sel = s;
        @(negedge clk); @(negedge clk);
        rst = 0;
        model_reset();
        cmp_model();
    endtask

    typedef struct {
        logic        rb;     // reset before this row
        logic        s;
        logic [1:0]  t;
        logic [31:0] d;
        logic        e_done;
        logic [4:0]  e_len;
        logic [31:0] e_ck;
        logic [15:0] e_pc;
        logic        e_err;
        logic [1:0]  e_code;
    } vec_t;

    vec_t tbl[13];

    initial begin
        rst = 1; sel = 0; valid = 0; flit = '0;

        // basic packet, stray/abort capture, overlength with backpressure
        tbl[0]  = '{1'b1, 1'b0, FLIT_TYPE_HEADER,  32'h01234567, 1'b0, 5'd0, 32'h0,        16'd0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b0, FLIT_TYPE_LAST,    32'hdeadbeef, 1'b1, 5'd2, 32'hDF8EFB88, 16'd1, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 1'b0, FLIT_TYPE_LAST,    32'h5,        1'b0, 5'd0, 32'h0,        16'd0, 1'b1, 2'd1};
        tbl[3]  = '{1'b0, 1'b0, FLIT_TYPE_HEADER,  32'h1,        1'b0, 5'd0, 32'h0,        16'd0, 1'b1, 2'd1};
        tbl[4]  = '{1'b0, 1'b0, FLIT_TYPE_HEADER,  32'h2,        1'b0, 5'd0, 32'h0,        16'd0, 1'b1, 2'd1};
        tbl[5]  = '{1'b0, 1'b0, FLIT_TYPE_LAST,    32'h3,        1'b1, 5'd2, 32'h1,        16'd1, 1'b1, 2'd1};
        tbl[6]  = '{1'b1, 1'b1, FLIT_TYPE_HEADER,  32'h1,        1'b0, 5'd0, 32'h0,        16'd0, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 1'b1, FLIT_TYPE_PAYLOAD, 32'h1,        1'b0, 5'd0, 32'h0,        16'd0, 1'b0, 2'd0};
        tbl[8]  = '{1'b0, 1'b1, FLIT_TYPE_PAYLOAD, 32'h1,        1'b0, 5'd0, 32'h0,        16'd0, 1'b0, 2'd0};
        tbl[9]  = '{1'b0, 1'b1, FLIT_TYPE_PAYLOAD, 32'h1,        1'b0, 5'd0, 32'h0,        16'd0, 1'b0, 2'd0};
        tbl[10] = '{1'b0, 1'b1, FLIT_TYPE_PAYLOAD, 32'h1,        1'b0, 5'd0, 32'h0,        16'd0, 1'b1, 2'd3};
        tbl[11] = '{1'b0, 1'b1, FLIT_TYPE_PAYLOAD, 32'h1,        1'b0, 5'd0, 32'h0,        16'd0, 1'b1, 2'd3};
        tbl[12] = '{1'b0, 1'b1, FLIT_TYPE_LAST,    32'h1,        1'b1, 5'd4, 32'h1,        16'd1, 1'b1, 2'd3};

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rb) do_reset(tbl[i].s);
            xfer(tbl[i].t, tbl[i].d);
            chk($sformatf("tbl%0d pkt_done", i), o_done, tbl[i].e_done);
            chk($sformatf("tbl%0d pkt_len", i), o_len, tbl[i].e_len);
            chk($sformatf("tbl%0d pkt_checksum", i), o_ck, tbl[i].e_ck);
            chk($sformatf("tbl%0d pkt_count", i), o_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d error", i), o_err, tbl[i].e_err);
            chk($sformatf("tbl%0d error_code", i), o_ec, tbl[i].e_code);
            if (i == 5) chk("stray error_flit", o_ef, {2'b10, 32'h5});
        end
        idle(2);

        // alternating ready with valid held high: 4 singles in 8 cycles
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) xfer(FLIT_TYPE_SINGLE, 32'h10 + i);
        chk("alt-ready flit_count", o_fc, 16'd4);
        chk("alt-ready cycles", cyc, 8);

        // asynchronous reset in the middle of a packet
        do_reset(1'b0);
        xfer(FLIT_TYPE_HEADER, 32'h11);
        xfer(FLIT_TYPE_PAYLOAD, 32'h22);
        #2 rst = 1;
        #1;
        chk("async rst flit_count", o_fc, 16'd0);
        chk("async rst pkt_done", o_done, 1'b0);
        chk("async rst pkt_len", o_len, 5'd0);
        chk("async rst ready_out", o_rdy, 1'b1);
        @(negedge clk);
        rst = 0;
        model_reset();
        xfer(FLIT_TYPE_SINGLE, 32'hAA);
        chk("post-rst pkt_len", o_len, 5'd1);
        chk("post-rst pkt_checksum", o_ck, 32'hAA);
        chk("post-rst pkt_count", o_pc, 16'd1);

        // randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            do_reset(s[0]);
            for (int i = 0; i < 400; i++) begin
                int r;
                logic [1:0] t;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                r = $urandom_range(0, 9);
                t = (r < 5) ? FLIT_TYPE_PAYLOAD : (r < 7) ? FLIT_TYPE_HEADER :
                    (r < 9) ? FLIT_TYPE_LAST : FLIT_TYPE_SINGLE;
                xfer(t, $urandom);
            end
        end

        // flit counter wrap
        do_reset(1'b0);
        for (int i = 0; i < 65535; i++) xfer(FLIT_TYPE_SINGLE, i);
        chk("preload flit_count", o_fc, 16'hFFFF);
        xfer(FLIT_TYPE_SINGLE, 32'h0);
        chk("wrap flit_count", o_fc, 16'd0);
        chk("wrap pkt_count", o_pc, 16'd0);
        chk("wrap error", o_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
